// File: rtl/snake_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_seq_ctrl_if
// Engine-side signal bundle between the game sequencer and the snake engine.
//   dead_flag, win_flag, score_flag : engine -> sequencer, 1-cycle pulses
//   step       : sequencer -> engine, 1-cycle advance enable
//   dir        : current heading (00 up, 01 right, 10 down, 11 left)
//   eng_clr    : 1-cycle engine clear pulse
//   game_state : 00 IDLE, 01 PLAY, 10 DEAD, 11 WIN
//   level      : speed level, saturating at 7
// Modports: master = sequencer, slave = engine.
// ---------------------------------------------------------------------------
interface snake_seq_ctrl_if;
    logic       dead_flag;
    logic       win_flag;
    logic       score_flag;
    logic       step;
    logic [1:0] dir;
    logic       eng_clr;
    logic [1:0] game_state;
    logic [2:0] level;

    modport master (
        input  dead_flag, win_flag, score_flag,
        output step, dir, eng_clr, game_state, level
    );

    modport slave (
        output dead_flag, win_flag, score_flag,
        input  step, dir, eng_clr, game_state, level
    );
endinterface

// File: rtl/snake_seq_ctrl.sv
// ---------------------------------------------------------------------------
// snake_seq_ctrl
// Game sequencer for the Snake engine: debounces the direction buttons,
// queues accepted turns in a 2-entry FIFO, produces the step enable from a
// score-accelerated period and runs the IDLE/PLAY/DEAD/WIN game FSM.
// Ports:
//   clk                    system clock
//   rst                    asynchronous reset, active low
//   up, right, left, down  raw buttons, active high, asynchronous
//   bus (master modport)   engine flags in; step/dir/eng_clr/game_state/level out
// Optional feature macro SNAKE_PAUSE_EN adds:
//   pause   raw pause button (same synchronize/debounce path)
//   paused  high while play is paused
//
//   state | meaning
//   IDLE  | after reset, waiting for a first press
//   PLAY  | engine running, steps issued, turns queued
//   DEAD  | engine reported death, steps held, queue frozen
//   WIN   | engine reported win, steps held, queue frozen
// ---------------------------------------------------------------------------
module snake_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BASE_PERIOD     = 7500000,
    parameter int SPEEDUP_STEP    = 500000,
    parameter int MIN_PERIOD      = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic right,
    input  logic left,
    input  logic down,
`ifdef SNAKE_PAUSE_EN
    input  logic pause,
    output logic paused,
`endif
    snake_seq_ctrl_if.master bus
);

`ifdef SNAKE_PAUSE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(BASE_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10,
        ST_WIN  = 2'b11
    } state_t;

    // Bit index doubles as the direction code: 0 up, 1 right, 2 down, 3 left.
    logic [NB-1:0]         raw;
    logic [NB-1:0]         sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, rise;
    logic [NB-1:0][DW-1:0] dcnt_q, dcnt_d;

    state_t          state_q, state_d;
    logic [1:0]      dir_q, dir_d, dir_o;
    logic [1:0][1:0] fifo_q, fifo_d, fifo_pop;
    logic [1:0]      fcnt_q, fcnt_d, fcnt_pop;
    logic [1:0]      ref_dir;
    logic [PW-1:0]   period_q, period_d, scnt_q, scnt_d;
    logic [2:0]      level_q, level_d;
    logic            step_o, clr_o, run_en;
    logic            evt_vld;
    logic [1:0]      evt_dir;

`ifdef SNAKE_PAUSE_EN
    logic paused_q, paused_d;
    assign raw    = {pause, left, down, right, up};
    assign run_en = ~paused_q;
    assign paused = paused_q;
`else
    assign raw    = {left, down, right, up};
    assign run_en = 1'b1;
`endif

    // Synchronizer and counter debouncer; rise marks a debounced 0->1 edge.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        rise    = '0;
        dcnt_d  = '0;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                    rise[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    // One direction event per cycle, priority up > right > down > left.
    always_comb begin
        evt_vld = |rise[3:0];
        evt_dir = 2'b11;
        if (rise[2]) evt_dir = 2'b10;
        if (rise[1]) evt_dir = 2'b01;
        if (rise[0]) evt_dir = 2'b00;
    end

    always_comb begin
        state_d  = state_q;
        dir_o    = dir_q;
        period_d = period_q;
        level_d  = level_q;
        scnt_d   = scnt_q;
        fifo_pop = fifo_q;
        fcnt_pop = fcnt_q;
        ref_dir  = dir_q;
        step_o   = 1'b0;
        clr_o    = 1'b0;
`ifdef SNAKE_PAUSE_EN
        paused_d = paused_q;
`endif
        if (state_q == ST_PLAY) begin
            if (run_en) begin
                if (scnt_q == '0) begin
                    step_o = 1'b1;
                    scnt_d = period_q - PW'(1);
                end else begin
                    scnt_d = scnt_q - PW'(1);
                end
            end
            // Pop first so dir is already the new heading in the step cycle.
            if (step_o && fcnt_q != 2'd0) begin
                dir_o       = fifo_q[0];
                fifo_pop[0] = fifo_q[1];
                fcnt_pop    = fcnt_q - 2'd1;
            end
            // Turns are checked against the post-pop tail (or heading).
            ref_dir = (fcnt_pop == 2'd0) ? dir_o :
                      (fcnt_pop == 2'd1) ? fifo_pop[0] : fifo_pop[1];
            if (evt_vld && run_en && evt_dir != ref_dir &&
                evt_dir != (ref_dir ^ 2'b10) && fcnt_pop != 2'd2) begin
                fifo_pop[fcnt_pop[0]] = evt_dir;
                fcnt_pop              = fcnt_pop + 2'd1;
            end
            if (bus.score_flag) begin
                if (period_q < PW'(MIN_PERIOD + SPEEDUP_STEP))
                    period_d = PW'(MIN_PERIOD);
                else
                    period_d = period_q - PW'(SPEEDUP_STEP);
                if (level_q != 3'd7)
                    level_d = level_q + 3'd1;
            end
            if (bus.win_flag)
                state_d = ST_WIN;
            else if (bus.dead_flag)
                state_d = ST_DEAD;
`ifdef SNAKE_PAUSE_EN
            if (rise[4])
                paused_d = ~paused_q;
            if (state_d != ST_PLAY)
                paused_d = 1'b0;
`endif
        end
        dir_d  = dir_o;
        fifo_d = fifo_pop;
        fcnt_d = fcnt_pop;
        // Restart from IDLE/DEAD/WIN; the triggering press is consumed here.
        if (state_q != ST_PLAY && evt_vld) begin
            clr_o    = 1'b1;
            state_d  = ST_PLAY;
            dir_d    = 2'b01;
            period_d = PW'(BASE_PERIOD);
            level_d  = 3'd0;
            fcnt_d   = 2'd0;
            scnt_d   = PW'(BASE_PERIOD - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            dcnt_q   <= '0;
            state_q  <= ST_IDLE;
            dir_q    <= 2'b01;
            fifo_q   <= '0;
            fcnt_q   <= 2'd0;
            period_q <= PW'(BASE_PERIOD);
            scnt_q   <= '0;
            level_q  <= 3'd0;
`ifdef SNAKE_PAUSE_EN
            paused_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            dcnt_q   <= dcnt_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            fifo_q   <= fifo_d;
            fcnt_q   <= fcnt_d;
            period_q <= period_d;
            scnt_q   <= scnt_d;
            level_q  <= level_d;
`ifdef SNAKE_PAUSE_EN
            paused_q <= paused_d;
`endif
        end
    end

    assign bus.step       = step_o;
    assign bus.dir        = dir_o;
    assign bus.eng_clr    = clr_o;
    assign bus.game_state = state_q;
    assign bus.level      = level_q;

endmodule

// File: tb/tb_snake_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_seq_ctrl
// Directed scenarios followed by a random phase. A behavioural model tracks
// the game at the level of "absolute cycle of the next step" and a turn queue.
// ---------------------------------------------------------------------------
module tb_snake_seq_ctrl;
    localparam int DEB  = 4;
    localparam int BASE = 20;
    localparam int SPD  = 4;
    localparam int MINP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0000;   // 0 up, 1 right, 2 down, 3 left

    snake_seq_ctrl_if sif ();

    snake_seq_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BASE_PERIOD     (BASE),
        .SPEEDUP_STEP    (SPD),
        .MIN_PERIOD      (MINP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .up    (btn[0]),
        .right (btn[1]),
        .left  (btn[3]),
        .down  (btn[2]),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc = 0;
    int d1[4], d2[4], lvl[4], runlen[4];
    int m_state, m_dir, m_level, m_period, m_next;
    int m_q[$];
    bit ev_valid;
    int ev_dir;
    int e_step, e_dir, e_clr;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            d1[i] = 0; d2[i] = 0; lvl[i] = 0; runlen[i] = 0;
        end
        m_state = 0; m_dir = 1; m_level = 0; m_period = BASE; m_next = 0;
        m_q.delete();
    endfunction

    function automatic void model_eval();
        ev_valid = 1'b0;
        ev_dir   = 0;
        for (int i = 3; i >= 0; i--)
            if (d2[i] == 1 && lvl[i] == 0 && runlen[i] == DEB - 1) begin
                ev_valid = 1'b1;
                ev_dir   = i;
            end
        e_clr  = (m_state != 1 && ev_valid) ? 1 : 0;
        e_step = (m_state == 1 && cyc == m_next) ? 1 : 0;
        e_dir  = (e_step == 1 && m_q.size() > 0) ? m_q[0] : m_dir;
    endfunction

    function automatic void model_update();
        int r;
        if (rst == 1'b0) begin
            model_reset();
            return;
        end
        if (m_state != 1) begin
            if (ev_valid) begin
                m_state = 1; m_dir = 1; m_period = BASE; m_level = 0;
                m_q.delete();
                m_next = cyc + BASE;
            end
        end else begin
            if (e_step == 1) begin
                if (m_q.size() > 0) m_dir = m_q.pop_front();
                m_next = cyc + m_period;
            end
            if (ev_valid) begin
                r = (m_q.size() > 0) ? m_q[$] : m_dir;
                if (ev_dir != r && ev_dir != (r ^ 2) && m_q.size() < 2)
                    m_q.push_back(ev_dir);
            end
            if (sif.score_flag) begin
                m_period = (m_period - SPD < MINP) ? MINP : m_period - SPD;
                m_level  = (m_level < 7) ? m_level + 1 : 7;
            end
            if (sif.win_flag)       m_state = 3;
            else if (sif.dead_flag) m_state = 2;
        end
        for (int i = 0; i < 4; i++) begin
            if (d2[i] != lvl[i]) begin
                if (runlen[i] == DEB - 1) begin
                    lvl[i] = d2[i];
                    runlen[i] = 0;
                end else begin
                    runlen[i]++;
                end
            end else begin
                runlen[i] = 0;
            end
            d2[i] = d1[i];
            d1[i] = int'(btn[i]);
        end
    endfunction

    // ---------------- observation ----------------
    int step_count = 0, last_step_cyc = 0, last_step_dir = 0;
    int clr_seen = 0, last_clr_cyc = 0, play_cyc = -1;

    task automatic cycle();
        @(negedge clk);
        model_eval();
        chk("step", 32'(sif.step), 32'(e_step));
        chk("eng_clr", 32'(sif.eng_clr), 32'(e_clr));
        chk("dir", 32'(sif.dir), 32'(e_dir));
        chk("game_state", 32'(sif.game_state), 32'(m_state));
        chk("level", 32'(sif.level), 32'(m_level));
        if (sif.step === 1'b1) begin
            step_count++; last_step_cyc = cyc; last_step_dir = int'(sif.dir);
        end
        if (sif.eng_clr === 1'b1) begin
            clr_seen++; last_clr_cyc = cyc;
        end
        if (sif.game_state === 2'b01 && play_cyc < 0) play_cyc = cyc;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        sif.dead_flag  = 1'b0;
        sif.win_flag   = 1'b0;
        sif.score_flag = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_step();
        int s = step_count;
        int k = 0;
        while (step_count == s && k < 200) begin
            cycle();
            k++;
        end
        if (step_count == s) chk("wait_step_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        int t_press, prev, c0, s0, b;
        int t[5];

        sif.dead_flag  = 1'b0;
        sif.win_flag   = 1'b0;
        sif.score_flag = 1'b0;
        model_reset();

        // Reset held, then released away from the clock edge.
        run(3);
        chk("reset_state", 32'(sif.game_state), 32'(0));
        chk("reset_dir", 32'(sif.dir), 32'(1));
        rst = 1'b1;
        run(2);

        // Bounce: 3 high cycles must not register.
        btn[1] = 1'b1; run(3);
        btn[1] = 1'b0; run(12);
        chk("bounce_state", 32'(sif.game_state), 32'(0));
        chk("bounce_clr", 32'(clr_seen), 32'(0));

        // Start.
        play_cyc = -1;
        btn[1] = 1'b1; t_press = cyc;
        run(10);
        btn[1] = 1'b0;
        chk("press_latency", 32'(play_cyc - t_press), 32'(6));
        chk("start_clr_once", 32'(clr_seen), 32'(1));
        wait_step();
        chk("first_step_gap", 32'(last_step_cyc - last_clr_cyc), 32'(BASE));
        chk("start_dir", 32'(last_step_dir), 32'(1));
        prev = last_step_cyc;
        wait_step();
        chk("start_spacing", 32'(last_step_cyc - prev), 32'(BASE));

        // Turns: reversal dropped, then up+left queued, down dropped (full).
        btn[3] = 1'b1; run(7);
        btn[3] = 1'b0;
        wait_step();
        chk("reversal_dropped", 32'(last_step_dir), 32'(1));
        btn[0] = 1'b1; run(2);
        btn[3] = 1'b1; run(6);
        btn[0] = 1'b0; run(2);
        btn[3] = 1'b0; btn[2] = 1'b1; run(7);
        btn[2] = 1'b0;
        wait_step();
        chk("turn1_dir", 32'(last_step_dir), 32'(0));
        wait_step();
        chk("turn2_dir", 32'(last_step_dir), 32'(3));
        wait_step();
        chk("full_dropped", 32'(last_step_dir), 32'(3));

        // Speedup.
        for (int i = 0; i < 4; i++) begin
            run(2);
            sif.score_flag = 1'b1;
            run(1);
            wait_step();
            t[i] = last_step_cyc;
        end
        wait_step();
        t[4] = last_step_cyc;
        chk("spacing_16", 32'(t[1] - t[0]), 32'(16));
        chk("spacing_12", 32'(t[2] - t[1]), 32'(12));
        chk("spacing_8a", 32'(t[3] - t[2]), 32'(8));
        chk("spacing_8b", 32'(t[4] - t[3]), 32'(8));
        chk("level_4", 32'(sif.level), 32'(4));

        // Dead and win together -> WIN, then restart with down.
        run(3);
        sif.dead_flag = 1'b1; sif.win_flag = 1'b1;
        run(1);
        chk("win_priority", 32'(sif.game_state), 32'(3));
        s0 = step_count;
        run(40);
        chk("no_steps_in_win", 32'(step_count - s0), 32'(0));
        c0 = clr_seen;
        btn[2] = 1'b1; run(8);
        btn[2] = 1'b0;
        chk("restart_clr", 32'(clr_seen - c0), 32'(1));
        chk("restart_level", 32'(sif.level), 32'(0));
        chk("restart_dir", 32'(sif.dir), 32'(1));
        wait_step();
        chk("restart_first_gap", 32'(last_step_cyc - last_clr_cyc), 32'(BASE));
        prev = last_step_cyc;
        wait_step();
        chk("restart_spacing", 32'(last_step_cyc - prev), 32'(BASE));

        // Reset mid-play with level 3 and one queued turn.
        for (int i = 0; i < 3; i++) begin
            sif.score_flag = 1'b1;
            run(1);
        end
        btn[0] = 1'b1; run(6);
        btn[0] = 1'b0; run(2);
        chk("pre_reset_level", 32'(sif.level), 32'(3));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_step", 32'(sif.step), 32'(0));
        chk("async_rst_clr", 32'(sif.eng_clr), 32'(0));
        chk("async_rst_dir", 32'(sif.dir), 32'(1));
        chk("async_rst_state", 32'(sif.game_state), 32'(0));
        chk("async_rst_level", 32'(sif.level), 32'(0));
        model_reset();
        run(3);
        rst = 1'b1;
        run(2);
        btn[1] = 1'b1; run(8);
        btn[1] = 1'b0;
        wait_step();
        chk("post_reset_dir1", 32'(last_step_dir), 32'(1));
        wait_step();
        chk("post_reset_dir2", 32'(last_step_dir), 32'(1));

        // Random phase against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(9) == 0) begin
                b = int'($urandom_range(3));
                btn[b] = ~btn[b];
            end
            if ($urandom_range(29) == 0)  sif.score_flag = 1'b1;
            if ($urandom_range(299) == 0) sif.dead_flag  = 1'b1;
            if ($urandom_range(399) == 0) sif.win_flag   = 1'b1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
